// File: rtl/alu_core_if.sv
// Operand/result bundle between the execute-stage control and the RV32I ALU.
// The master drives the operation and operands; the ALU (slave) returns results.
interface alu_core_if #(
   parameter int D_WIDTH = 32
);
   logic               alusrc;
   logic [3:0]         aluctrl;
   logic [D_WIDTH-1:0] aluop1;
   logic [D_WIDTH-1:0] immop;
   logic [D_WIDTH-1:0] regop2;
   logic [D_WIDTH-1:0] aluout;
   logic               eq;
   logic [D_WIDTH-1:0] aluout_q;
   logic               eq_q;

   modport master (
      output alusrc, aluctrl, aluop1, immop, regop2,
      input  aluout, eq, aluout_q, eq_q
   );

   modport slave (
      input  alusrc, aluctrl, aluop1, immop, regop2,
      output aluout, eq, aluout_q, eq_q
   );
endinterface

// File: rtl/alu_core.sv
// RV32I integer ALU: combinational result and non-zero flag for branch decisions,
// plus registered copies of both for pipeline/debug observation.
module alu_core #(
   parameter int D_WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_core_if.slave bus
);
   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b1000;
   localparam logic [3:0] OP_SLL   = 4'b0001;
   localparam logic [3:0] OP_SLT   = 4'b0010;
   localparam logic [3:0] OP_SLTU  = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SRL   = 4'b0101;
   localparam logic [3:0] OP_SRA   = 4'b1101;
   localparam logic [3:0] OP_OR    = 4'b0110;
   localparam logic [3:0] OP_AND   = 4'b0111;
   localparam logic [3:0] OP_PASSB = 4'b1001;

   logic [D_WIDTH-1:0] opb_s;
   logic [4:0]         shamt_s;
   logic [D_WIDTH-1:0] result_s;
   logic               flag_s;
   logic [D_WIDTH-1:0] result_d;
   logic               flag_d;
   logic [D_WIDTH-1:0] result_q;
   logic               flag_q;

   // Operand-B select and operation decode; only the shift amount bits of B feed shifts.
   always_comb begin
      opb_s    = bus.alusrc ? bus.immop : bus.regop2;
      shamt_s  = opb_s[4:0];
      result_s = {D_WIDTH{1'b0}};
      case (bus.aluctrl)
         OP_ADD:   result_s = bus.aluop1 + opb_s;
         OP_SUB:   result_s = bus.aluop1 - opb_s;
         OP_SLL:   result_s = bus.aluop1 << shamt_s;
         OP_SLT:   result_s = {{(D_WIDTH-1){1'b0}}, ($signed(bus.aluop1) < $signed(opb_s))};
         OP_SLTU:  result_s = {{(D_WIDTH-1){1'b0}}, (bus.aluop1 < opb_s)};
         OP_XOR:   result_s = bus.aluop1 ^ opb_s;
         OP_SRL:   result_s = bus.aluop1 >> shamt_s;
         OP_SRA:   result_s = $unsigned($signed(bus.aluop1) >>> shamt_s);
         OP_OR:    result_s = bus.aluop1 | opb_s;
         OP_AND:   result_s = bus.aluop1 & opb_s;
         OP_PASSB: result_s = opb_s;
         default:  result_s = {D_WIDTH{1'b0}};
      endcase
      flag_s   = |result_s;
      result_d = result_s;
      flag_d   = flag_s;
   end

   // Observation registers capture every cycle; reset clears them asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= {D_WIDTH{1'b0}};
         flag_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         flag_q   <= flag_d;
      end
   end

   assign bus.aluout   = result_s;
   assign bus.eq       = flag_s;
   assign bus.aluout_q = result_q;
   assign bus.eq_q     = flag_q;
endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core with hand-computed expected values.
module tb_alu_core;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_core_if #(.D_WIDTH(32)) bus ();

   alu_core #(.D_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic src, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] imm, input logic [31:0] r2);
      @(negedge clk);
      bus.alusrc  = src;
      bus.aluctrl = ctrl;
      bus.aluop1  = a;
      bus.immop   = imm;
      bus.regop2  = r2;
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (bus.aluout_q !== 32'h0 || bus.eq_q !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs: got aluout_q=%h eq_q=%b, want 0/0", bus.aluout_q, bus.eq_q);
      end
      drive(1'b0, 4'b0000, 32'd1, 32'd0, 32'd1);
      checks++;
      if (bus.aluout !== 32'd2 || bus.eq !== 1'b1) begin
         errors++;
         $display("FAIL comb_in_reset: got %h/%b, want 00000002/1", bus.aluout, bus.eq);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.aluout_q !== 32'h0 || bus.eq_q !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got aluout_q=%h eq_q=%b, want 0/0", bus.aluout_q, bus.eq_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add_sub();
      logic [3:0]  c [6] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
      logic [31:0] a [6] = '{32'd5, 32'd5, 32'd7, 32'd0, 32'h7FFFFFFF, 32'h0};
      logic [31:0] b [6] = '{32'd3, 32'd3, 32'd7, 32'd1, 32'd1, 32'h0};
      logic [31:0] x [6] = '{32'd8, 32'd2, 32'd0, 32'hFFFFFFFF, 32'h80000000, 32'h0};
      logic        e [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, c[i], a[i], 32'hDEADBEEF, b[i]);
         checks++;
         if (bus.aluout !== x[i] || bus.eq !== e[i]) begin
            errors++;
            $display("FAIL add_sub[%0d]: got %h/%b, want %h/%b", i, bus.aluout, bus.eq, x[i], e[i]);
         end
      end
   endtask

   task automatic test_mux();
      drive(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFC, 32'h1234);
      checks++;
      if (bus.aluout !== 32'h0000000C || bus.eq !== 1'b1) begin
         errors++;
         $display("FAIL mux_imm: got %h/%b, want 0000000c/1", bus.aluout, bus.eq);
      end
      drive(1'b0, 4'b1001, 32'h10, 32'hFFFFFFFC, 32'h1234);
      checks++;
      if (bus.aluout !== 32'h00001234) begin
         errors++;
         $display("FAIL mux_reg: got %h, want 00001234", bus.aluout);
      end
   endtask

   task automatic test_shift();
      logic [3:0]  c [7] = '{4'b0001, 4'b0101, 4'b1101, 4'b0001, 4'b0101, 4'b1101, 4'b1101};
      logic [31:0] b [7] = '{32'd4, 32'd4, 32'd4, 32'h24, 32'h24, 32'h24, 32'h20};
      logic [31:0] x [7] = '{32'h00000100, 32'h08000001, 32'hF8000001,
                             32'h00000100, 32'h08000001, 32'hF8000001, 32'h80000010};
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, c[i], 32'h80000010, b[i], 32'h0000001F);
         checks++;
         if (bus.aluout !== x[i]) begin
            errors++;
            $display("FAIL shift[%0d]: got %h, want %h", i, bus.aluout, x[i]);
         end
      end
   endtask

   task automatic test_compare();
      logic [3:0]  c [5] = '{4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0010};
      logic [31:0] a [5] = '{32'h80000000, 32'h80000000, 32'd5, 32'd1, 32'd1};
      logic [31:0] b [5] = '{32'd1, 32'd1, 32'd5, 32'h80000000, 32'h80000000};
      logic [31:0] x [5] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd0};
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, c[i], a[i], 32'h0, b[i]);
         checks++;
         if (bus.aluout !== x[i] || bus.eq !== x[i][0]) begin
            errors++;
            $display("FAIL compare[%0d]: got %h/%b, want %h/%b", i, bus.aluout, bus.eq, x[i], x[i][0]);
         end
      end
   endtask

   task automatic test_logic();
      logic [3:0]  c [5] = '{4'b0111, 4'b0110, 4'b0100, 4'b1001, 4'b1111};
      logic [31:0] x [5] = '{32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0};
      logic        e [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, c[i], 32'hF0F0F0F0, 32'h12345678, 32'h0FF00FF0);
         checks++;
         if (bus.aluout !== x[i] || bus.eq !== e[i]) begin
            errors++;
            $display("FAIL logic[%0d]: got %h/%b, want %h/%b", i, bus.aluout, bus.eq, x[i], e[i]);
         end
      end
   endtask

   task automatic test_registers();
      drive(1'b0, 4'b0000, 32'd2, 32'h0, 32'd2);
      @(posedge clk); #1;
      checks++;
      if (bus.aluout_q !== 32'd4 || bus.eq_q !== 1'b1) begin
         errors++;
         $display("FAIL reg_add: got %h/%b, want 00000004/1", bus.aluout_q, bus.eq_q);
      end
      drive(1'b0, 4'b1000, 32'd7, 32'h0, 32'd7);
      checks++;
      if (bus.aluout_q !== 32'd4) begin
         errors++;
         $display("FAIL reg_latency: got %h before edge, want 00000004", bus.aluout_q);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.aluout_q !== 32'd0 || bus.eq_q !== 1'b0) begin
         errors++;
         $display("FAIL reg_sub_zero: got %h/%b, want 00000000/0", bus.aluout_q, bus.eq_q);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 4'b0000, 32'd2, 32'h0, 32'd2);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.aluout_q !== 32'h0 || bus.eq_q !== 1'b0 || bus.aluout !== 32'd4) begin
         errors++;
         $display("FAIL async_reset: got q=%h eq_q=%b aluout=%h, want 0/0/00000004",
                  bus.aluout_q, bus.eq_q, bus.aluout);
      end
      drive(1'b0, 4'b0000, 32'd3, 32'h0, 32'd4);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.aluout_q !== 32'd7 || bus.eq_q !== 1'b1) begin
         errors++;
         $display("FAIL release_capture: got %h/%b, want 00000007/1", bus.aluout_q, bus.eq_q);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      bus.alusrc  = 1'b0;
      bus.aluctrl = 4'b0000;
      bus.aluop1  = 32'h0;
      bus.immop   = 32'h0;
      bus.regop2  = 32'h0;
      test_reset();
      test_add_sub();
      test_mux();
      test_shift();
      test_compare();
      test_logic();
      test_registers();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- RV32I integer ALU for the single-cycle execute stage.
- Selects operand B from the register file or the immediate, then performs the arithmetic, logic, shift or compare operation chosen by `aluctrl`.
- Outputs a combinational result plus a non-zero flag named `eq`, which the branch logic consumes.
- Also provides registered copies of the result and flag for pipeline and debug observation.

Parameters:
- D_WIDTH, 32, datapath width in bits (shift amount uses the low 5 bits; D_WIDTH is fixed at 32 for RV32I).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- alusrc  input  1  operand-B select: 1 = immop, 0 = regop2
- aluctrl  input  4  operation select (encoding below)
- aluop1  input  D_WIDTH  operand A (rs1 or PC, muxed upstream)
- immop  input  D_WIDTH  sign-extended immediate
- regop2  input  D_WIDTH  rs2 value
- aluout  output  D_WIDTH  combinational result
- eq  output  1  combinational flag, 1 when aluout != 0
- aluout_q  output  D_WIDTH  aluout registered on clk
- eq_q  output  1  eq registered on clk

Behaviour:
- Interface: one clock (`clk`); reset `rst_n` is asynchronous and active-low.
- Operand B: `opb = alusrc ? immop : regop2`, purely combinational.
- aluctrl encoding (A = aluop1, B = opb):
  - 0000 ADD: A + B, modulo 2^32, carry discarded.
  - 1000 SUB: A - B, modulo 2^32.
  - 0001 SLL: A << B[4:0].
  - 0010 SLT: 1 if signed(A) < signed(B), else 0 (zero-extended).
  - 0011 SLTU: 1 if unsigned(A) < unsigned(B), else 0.
  - 0100 XOR: A ^ B.
  - 0101 SRL: logical shift right of A by B[4:0].
  - 1101 SRA: arithmetic shift right of A by B[4:0], sign bit replicated.
  - 0110 OR: A | B.
  - 0111 AND: A & B.
  - 1001 PASSB: B (used for LUI).
  - Any other code: aluout = 0.
- Shifts ignore B[31:5]. A shift amount of 0 returns A unchanged.
- eq = reduction-OR of aluout. It is an unequal/true flag:
  - After SUB, eq=0 means A==B.
  - After SLT or SLTU, eq=1 means less-than.
- Branch usage downstream:
  - BEQ, BGE, BGEU are taken when eq=0.
  - BNE, BLT, BLTU are taken when eq=1.
- aluout and eq have zero latency and no dependence on clk or rst_n. They are valid in the same cycle as their inputs.
- aluout_q and eq_q:
  - Capture aluout and eq on every rising clk edge. There is no enable.
  - One-cycle latency.
- Reset:
  - rst_n low asynchronously forces aluout_q = 0 and eq_q = 0, immediately and regardless of clk.
  - These values hold while rst_n is low.
  - The first capture happens on the first rising clk edge after rst_n deasserts.
  - Combinational outputs remain live during reset.
- Boundary conditions:
  - Overflow wraps: 0x7FFFFFFF + 1 = 0x80000000, with no flag.
  - SLT vs SLTU on 0x80000000 vs 0x00000001: SLT returns 1, SLTU returns 0.
- No X propagation from unused ports. The unselected operand never affects the result.

Test Plan:
- ADD and SUB:
  - alusrc=0, A=5, regop2=3, aluctrl=0000 -> aluout=8, eq=1.
  - aluctrl=1000 -> aluout=2.
  - A=7, B=7, SUB -> aluout=0, eq=0.
  - A=0, B=1, SUB -> aluout=0xFFFFFFFF.
- Operand-B mux: alusrc=1, immop=0xFFFFFFFC, regop2=0x1234, A=0x10, ADD -> aluout=0x0000000C (regop2 ignored).
- Shifts, A=0x80000010, B=4:
  - SLL -> 0x00000100.
  - SRL -> 0x08000001.
  - SRA -> 0xF8000001.
  - B=0x24 (low 5 bits = 4) gives identical results.
- Compares, A=0x80000000, B=1:
  - SLT -> aluout=1, eq=1.
  - SLTU -> aluout=0, eq=0.
  - A=B=5, SLT -> 0.
- Logic and pass, A=0xF0F0F0F0, B=0x0FF00FF0:
  - AND -> 0x00F000F0.
  - OR -> 0xFFF0FFF0.
  - XOR -> 0xFF00FF00.
  - PASSB (1001) -> 0x0FF00FF0.
  - Undefined code 1111 -> 0, eq=0.
- Registers and reset:
  - ADD 2+2 applied -> aluout_q=4 and eq_q=1 one edge later.
  - Drop rst_n mid-cycle -> aluout_q=0 and eq_q=0 immediately, with no clk edge.
  - Release rst_n -> next edge captures the current aluout.
